riscy_mem_responder: RTL and testbench

- Memory-side responder for the RISCY core's load/store and fetch requests. The core's sequencer issues RD/WR strobes with address and data; this block completes them with a 4-phase ACK handshake after a programmable number of wait states.
- Holds a 2**AW x DW register-file memory.
- Sits beside RISCY at the top level, on the far end of the core's memory interface.

---
 rtl/riscy_pkg.sv | 8 +
 rtl/riscy_mem_array.sv | 29 ++
 rtl/riscy_mem_responder.sv | 101 ++++++++++
 tb/tb_riscy_mem_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscy_pkg.sv
// Shared types for the RISCY memory responder: FSM states, op encoding, default widths.
package riscy_pkg;
  localparam int DEF_AW = 5;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {IDLE, WAIT, ACKH, RELEASE} mem_state_t;
  typedef enum logic {OP_RD, OP_WR} mem_op_t;
endpackage

// File: rtl/riscy_mem_array.sv
// 2**AW x DW register file: synchronous write, registered read, async active-low clear.
module riscy_mem_array
  import riscy_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [2**AW-1:0][DW-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      // rdata only moves on a read, so writes leave the last read value visible
      if (re) rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/riscy_mem_responder.sv
// Memory-side responder: accepts RD/WR level requests, waits WAIT_STATES cycles,
// completes with a 4-phase ACK handshake against an internal register file.
module riscy_mem_responder
  import riscy_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int WAIT_STATES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] DIN,
  input  logic          RD,
  input  logic          WR,
  output logic [DW-1:0] DOUT,
  output logic          ACK,
  output logic          BUSY,
  output logic          ERR
);
  typedef struct packed {
    mem_op_t       op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  mem_state_t    state;
  logic [3:0]    cnt;
  req_t          req;
  logic          accept, fire, strobe;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  mem_op_t       m_op;

  assign accept = (state == IDLE) && (RD ^ WR);
  // With zero wait states the access happens on the accept edge itself, so the
  // array is fed from the live inputs instead of the (not yet loaded) latch.
  assign m_addr = (state == IDLE) ? ADDR : req.addr;
  assign m_data = (state == IDLE) ? DIN  : req.data;
  assign m_op   = (state == IDLE) ? (WR ? OP_WR : OP_RD) : req.op;
  assign fire   = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (cnt == 4'd1));
  assign strobe = (req.op == OP_WR) ? WR : RD;

  riscy_mem_array #(.AW(AW), .DW(DW)) u_array (
    .clk   (CLK),
    .rst_n (RST),
    .we    (fire && (m_op == OP_WR)),
    .waddr (m_addr),
    .wdata (m_data),
    .re    (fire && (m_op == OP_RD)),
    .raddr (m_addr),
    .rdata (DOUT)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= '0;
      ACK   <= 1'b0;
      BUSY  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req  <= '{op: m_op, addr: ADDR, data: DIN};
            BUSY <= 1'b1;
            cnt  <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state <= ACKH;
              ACK   <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else if (RD && WR) begin
            ERR <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ACKH;
            ACK   <= 1'b1;
          end
        end
        // An initiator that dropped its strobe during WAIT falls straight through here
        ACKH: begin
          if (!strobe) begin
            ACK   <= 1'b0;
            BUSY  <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscy_mem_responder.sv
// Directed bench: default instance (WAIT_STATES=2) plus a zero-wait-state instance.
module tb_riscy_mem_responder;
  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] ADDR, addr0;
  logic [7:0] DIN, din0, DOUT, dout0;
  logic       RD, WR, ACK, BUSY, ERR;
  logic       rd0, wr0, ack0, busy0, err0;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  riscy_mem_responder dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DIN(DIN), .RD(RD), .WR(WR),
    .DOUT(DOUT), .ACK(ACK), .BUSY(BUSY), .ERR(ERR)
  );

  riscy_mem_responder #(.WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RST(RST), .ADDR(addr0), .DIN(din0), .RD(rd0), .WR(wr0),
    .DOUT(dout0), .ACK(ack0), .BUSY(busy0), .ERR(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_mem(input logic [4:0] a, input logic [7:0] d);
    ADDR = a; DIN = d; WR = 1'b1;
    repeat (3) step();
    chk("wr_ack", ACK, 1);
    WR = 1'b0;
    step(); step();
  endtask

  task automatic rd_mem(input logic [4:0] a, input logic [7:0] exp, input string tag);
    ADDR = a; RD = 1'b1;
    repeat (3) step();
    chk({tag, "_ack"}, ACK, 1);
    chk(tag, DOUT, exp);
    RD = 1'b0;
    step(); step();
  endtask

  initial begin
    RST = 1'b0; RD = 1'b0; WR = 1'b0; ADDR = '0; DIN = '0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
    #2;
    chk("rst_ack", ACK, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR, 0);
    chk("rst_dout", DOUT, 0);
    step(); step();
    RST = 1'b1;
    step();

    // write 0x5C to 0x0A with the latency walked edge by edge
    ADDR = 5'h0A; DIN = 8'h5C; WR = 1'b1;
    step();
    chk("wr_e1_busy", BUSY, 1);
    chk("wr_e1_ack", ACK, 0);
    step();
    chk("wr_e2_ack", ACK, 0);
    step();
    chk("wr_e3_ack", ACK, 1);
    chk("wr_dout_unchanged", DOUT, 0);
    WR = 1'b0;
    step();
    chk("wr_drop_ack", ACK, 0);
    chk("wr_drop_busy", BUSY, 0);
    step();
    rd_mem(5'h0A, 8'h5C, "rd_0a");

    // RD and WR together: ERR every cycle, no accept
    ADDR = 5'h03; DIN = 8'hFF; RD = 1'b1; WR = 1'b1;
    step();
    chk("ill_err1", ERR, 1);
    chk("ill_busy1", BUSY, 0);
    step();
    chk("ill_err2", ERR, 1);
    chk("ill_busy2", BUSY, 0);
    RD = 1'b0; WR = 1'b0;
    step();
    chk("ill_err_clr", ERR, 0);
    rd_mem(5'h03, 8'h00, "ill_mem3");

    // initiator abort during WAIT still commits the write
    ADDR = 5'h07; DIN = 8'h33; WR = 1'b1;
    step();
    chk("abt_busy", BUSY, 1);
    WR = 1'b0;
    step();
    chk("abt_e2_ack", ACK, 0);
    step();
    chk("abt_e3_ack", ACK, 1);
    step();
    chk("abt_e4_ack", ACK, 0);
    chk("abt_e4_busy", BUSY, 0);
    step();
    rd_mem(5'h07, 8'h33, "abt_mem7");

    // input changes during ACKH of a read are ignored
    wr_mem(5'h02, 8'h11);
    wr_mem(5'h04, 8'h44);
    ADDR = 5'h02; RD = 1'b1;
    repeat (3) step();
    chk("hold_ack", ACK, 1);
    chk("hold_dout", DOUT, 8'h11);
    ADDR = 5'h04; DIN = 8'h99; WR = 1'b1;
    step();
    chk("hold_ack2", ACK, 1);
    chk("hold_dout2", DOUT, 8'h11);
    chk("hold_err", ERR, 0);
    WR = 1'b0;
    step();
    chk("hold_dout3", DOUT, 8'h11);
    RD = 1'b0;
    step();
    chk("hold_rel_ack", ACK, 0);
    step();
    rd_mem(5'h04, 8'h44, "hold_mem4");

    // zero wait states: ACK one edge after accept, 3-cycle back-to-back reads
    addr0 = 5'h1F; din0 = 8'hA7; wr0 = 1'b1;
    step();
    chk("ws0_wr_ack", ack0, 1);
    wr0 = 1'b0;
    step(); step();
    rd0 = 1'b1;
    step();
    chk("ws0_rd_ack", ack0, 1);
    chk("ws0_rd_dout", dout0, 8'hA7);
    chk("ws0_rd_busy", busy0, 1);
    rd0 = 1'b0;
    step();
    chk("ws0_rel_ack", ack0, 0);
    addr0 = 5'h00; rd0 = 1'b1;
    step();
    chk("ws0_b2b_wait", ack0, 0);
    step();
    chk("ws0_b2b_ack", ack0, 1);
    chk("ws0_b2b_dout", dout0, 8'h00);
    rd0 = 1'b0;
    step(); step();

    // async reset in the middle of WAIT
    rd_mem(5'h0A, 8'h5C, "pre_rst_rd");
    ADDR = 5'h10; DIN = 8'hEE; WR = 1'b1;
    step();
    chk("mid_busy", BUSY, 1);
    #2 RST = 1'b0;
    #1;
    chk("async_ack", ACK, 0);
    chk("async_busy", BUSY, 0);
    chk("async_dout", DOUT, 0);
    WR = 1'b0;
    step();
    RST = 1'b1;
    step();
    rd_mem(5'h0A, 8'h00, "post_rst_0a");
    rd_mem(5'h10, 8'h00, "post_rst_10");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
